ksa_pipe_adder: RTL and testbench

Parametrised, pipelined Kogge-Stone adder with one register stage per prefix level and valid/ready handshakes on both sides. It is the clocked, width-generic successor to the fixed-width combinational Kogge-Stone adders. It serves as the adder primitive for the multiplier final-addition stage and for other wide datapath sums. An optional sideband tag travels with each operation so that upstream logic can match results to requests.

---
 rtl/ksa_pkg.sv | 10 +
 rtl/ksa_prefix_level.sv | 22 ++
 rtl/ksa_pipe_adder.sv | 148 ++++++++++++++
 tb/tb_ksa_pipe_adder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone adder.
package ksa_pkg;

   localparam int KSA_MAX_WIDTH = 128;

   function automatic int ksa_levels(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One Kogge-Stone prefix level: black cells for i >= DIST, wires below.
module ksa_prefix_level #(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] g_in,
   input  logic [WIDTH-1:0] p_in,
   output logic [WIDTH-1:0] g_out,
   output logic [WIDTH-1:0] p_out
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < DIST) begin : g_pass
         assign g_out[i] = g_in[i];
         assign p_out[i] = p_in[i];
      end else begin : g_cell
         assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-DIST]);
         assign p_out[i] = p_in[i] & p_in[i-DIST];
      end
   end

endmodule

// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone adder, one register stage per prefix level.
// Optional KSA_SUB_EN adds the sub input and the ovf output.
module ksa_pipe_adder
   import ksa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef KSA_SUB_EN
   input  logic             sub,
`endif
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef KSA_SUB_EN
   output logic             ovf,
`endif
   output logic [TAG_W-1:0] out_tag
);

   localparam int LEVELS = ksa_levels(WIDTH);

   if (WIDTH < 2 || WIDTH > KSA_MAX_WIDTH) begin : g_bad_width
      $error("ksa_pipe_adder: WIDTH out of range");
   end

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;
   logic [WIDTH-1:0] g_s0;
   logic [WIDTH-1:0] p_s0;

   logic [LEVELS:0]             v_q;
   logic [LEVELS:0]             c_q;
   logic [LEVELS:0][WIDTH-1:0]  g_q;
   logic [LEVELS:0][WIDTH-1:0]  p_q;
   logic [LEVELS:0][WIDTH-1:0]  po_q;
   logic [LEVELS:0][TAG_W-1:0]  t_q;
   logic [LEVELS:1][WIDTH-1:0]  g_n;
   logic [LEVELS:1][WIDTH-1:0]  p_n;

   logic [WIDTH-1:0] sum_n;
   logic             cout_n;
   logic             unused_p;

   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

`ifdef KSA_SUB_EN
   assign b_eff = b ^ {WIDTH{sub}};
   assign c_eff = cin ^ sub;
`else
   assign b_eff = b;
   assign c_eff = cin;
`endif

   // Carry-in folds into bit 0 so the prefix tree sees a single chain.
   always_comb begin
      p_s0    = a ^ b_eff;
      g_s0    = a & b_eff;
      g_s0[0] = g_s0[0] | (p_s0[0] & c_eff);
   end

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      ksa_prefix_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << (k - 1))
      ) u_lvl (
         .g_in  (g_q[k-1]),
         .p_in  (p_q[k-1]),
         .g_out (g_n[k]),
         .p_out (p_n[k])
      );
   end

   assign sum_n    = po_q[LEVELS] ^ {g_q[LEVELS][WIDTH-2:0], c_q[LEVELS]};
   assign cout_n   = g_q[LEVELS][WIDTH-1];
   assign unused_p = ^p_q[LEVELS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q       <= '0;
         c_q       <= '0;
         g_q       <= '0;
         p_q       <= '0;
         po_q      <= '0;
         t_q       <= '0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         out_tag   <= '0;
      end else if (adv) begin
         v_q[0]  <= in_valid;
         c_q[0]  <= c_eff;
         g_q[0]  <= g_s0;
         p_q[0]  <= p_s0;
         po_q[0] <= p_s0;
         t_q[0]  <= in_tag;
         for (int k = 1; k <= LEVELS; k++) begin
            v_q[k]  <= v_q[k-1];
            c_q[k]  <= c_q[k-1];
            g_q[k]  <= g_n[k];
            p_q[k]  <= p_n[k];
            po_q[k] <= po_q[k-1];
            t_q[k]  <= t_q[k-1];
         end
         out_valid <= v_q[LEVELS];
         sum       <= sum_n;
         cout      <= cout_n;
         out_tag   <= t_q[LEVELS];
      end
   end

`ifdef KSA_SUB_EN
   logic [LEVELS:0] am_q;
   logic [LEVELS:0] bm_q;
   logic            ovf_n;

   assign ovf_n = (am_q[LEVELS] == bm_q[LEVELS])
                & (sum_n[WIDTH-1] != am_q[LEVELS]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         am_q <= '0;
         bm_q <= '0;
         ovf  <= 1'b0;
      end else if (adv) begin
         am_q[0] <= a[WIDTH-1];
         bm_q[0] <= b_eff[WIDTH-1];
         for (int k = 1; k <= LEVELS; k++) begin
            am_q[k] <= am_q[k-1];
            bm_q[k] <= bm_q[k-1];
         end
         ovf <= ovf_n;
      end
   end
`endif

endmodule

// File: tb/tb_ksa_pipe_adder.sv
// Random and directed bench for ksa_pipe_adder at WIDTH 8, 13 and 32.
// Exercises sub/ovf too when KSA_SUB_EN is defined.
module tb_ksa_pipe_adder;

   typedef struct {
      logic [31:0] s;
      logic        c;
      logic        o;
      logic [7:0]  t;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   exp_t q[$];

   logic        iv32, ir32, ov32, or32, cin32, sub32, cout32;
   logic [31:0] a32, b32, s32;
   logic [7:0]  ti32, to32;
   logic        iv8, ir8, ov8, or8, cin8, sub8, cout8;
   logic [7:0]  a8, b8, s8;
   logic        ti8, to8;
   logic        iv13, ir13, ov13, or13, cin13, sub13, cout13;
   logic [12:0] a13, b13, s13;
   logic        ti13, to13;
`ifdef KSA_SUB_EN
   logic        ovf32, ovf8, ovf13;
`endif

   ksa_pipe_adder #(.WIDTH(32), .TAG_W(8)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
      .a(a32), .b(b32), .cin(cin32),
`ifdef KSA_SUB_EN
      .sub(sub32),
`endif
      .in_tag(ti32), .out_valid(ov32), .out_ready(or32),
      .sum(s32), .cout(cout32),
`ifdef KSA_SUB_EN
      .ovf(ovf32),
`endif
      .out_tag(to32)
   );

   ksa_pipe_adder #(.WIDTH(8), .TAG_W(1)) dut8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .cin(cin8),
`ifdef KSA_SUB_EN
      .sub(sub8),
`endif
      .in_tag(ti8), .out_valid(ov8), .out_ready(or8),
      .sum(s8), .cout(cout8),
`ifdef KSA_SUB_EN
      .ovf(ovf8),
`endif
      .out_tag(to8)
   );

   ksa_pipe_adder #(.WIDTH(13), .TAG_W(1)) dut13 (
      .clk(clk), .rst(rst), .in_valid(iv13), .in_ready(ir13),
      .a(a13), .b(b13), .cin(cin13),
`ifdef KSA_SUB_EN
      .sub(sub13),
`endif
      .in_tag(ti13), .out_valid(ov13), .out_ready(or13),
      .sum(s13), .cout(cout13),
`ifdef KSA_SUB_EN
      .ovf(ovf13),
`endif
      .out_tag(to13)
   );

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Plain integer reference: returns {ovf, cout, sum[31:0]} for w <= 32.
   function automatic logic [33:0] ref_add(input int w, input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic c, input logic s);
      longint mask, ux, uy, full, sx, sy, r, hi, lo;
      logic [31:0] sm;
      logic co, ov;
      mask = (longint'(1) << w) - 1;
      ux = longint'(x) & mask;
      uy = longint'(y) & mask;
      if (s) full = ux + ((~uy) & mask) + (c ? 0 : 1);
      else   full = ux + uy + (c ? 1 : 0);
      sm = 32'(full & mask);
      co = ((full >> w) & 1) != 0;
      sx = ux[w-1] ? ux - (longint'(1) << w) : ux;
      sy = uy[w-1] ? uy - (longint'(1) << w) : uy;
      r  = s ? sx - sy - (c ? 1 : 0) : sx + sy + (c ? 1 : 0);
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -(longint'(1) << (w - 1));
      ov = (r > hi) || (r < lo);
      return {ov, co, sm};
   endfunction

   task automatic run8(input logic [7:0] x, input logic [7:0] y,
                       input logic c, input logic s, output int lat);
      @(negedge clk);
      a8 = x; b8 = y; cin8 = c; sub8 = s; ti8 = 1'b1; iv8 = 1'b1; or8 = 1'b1;
      @(posedge clk);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         iv8 = 1'b0;
         if (ov8) begin lat = n; break; end
      end
   endtask

   task automatic run13(input logic [12:0] x, input logic [12:0] y,
                        input logic c, output int lat);
      @(negedge clk);
      a13 = x; b13 = y; cin13 = c; sub13 = 1'b0; ti13 = 1'b1;
      iv13 = 1'b1; or13 = 1'b1;
      @(posedge clk);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         iv13 = 1'b0;
         if (ov13) begin lat = n; break; end
      end
   endtask

   // One cycle on the 32-bit instance: score the result leaving, model the one entering.
   task automatic step32(input bit rdy, input bit val);
      logic [33:0] e;
      exp_t x;
      @(negedge clk);
      or32 = rdy; iv32 = val;
      a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom); ti32 = 8'($urandom);
`ifdef KSA_SUB_EN
      sub32 = 1'($urandom);
`endif
      #1;
      check("in_ready", {127'd0, ir32}, {127'd0, !ov32 | or32});
      if (ov32 && or32) begin
         if (q.size() == 0) begin
            check("extra_result", 128'd1, 128'd0);
         end else begin
            x = q.pop_front();
            check("res32", {to32, cout32, s32}, {x.t, x.c, x.s});
`ifdef KSA_SUB_EN
            check("ovf32", {127'd0, ovf32}, {127'd0, x.o});
`endif
         end
      end
      if (iv32 && ir32) begin
         e = ref_add(32, a32, b32, cin32, sub32);
         x.s = e[31:0]; x.c = e[32]; x.o = e[33]; x.t = ti32;
         q.push_back(x);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int lat;
      int misses;
      logic [33:0] e;
      logic [40:0] snap;
      exp_t x;

      rst = 1'b1;
      {iv32, or32, cin32, sub32, a32, b32, ti32} = '0;
      {iv8, or8, cin8, sub8, a8, b8, ti8} = '0;
      {iv13, or13, cin13, sub13, a13, b13, ti13} = '0;
      repeat (2) @(negedge clk);
      check("rst_valid", {127'd0, ov32}, 128'd0);
      check("rst_out", {to32, cout32, s32}, 128'd0);
      check("rst_ready", {127'd0, ir32}, 128'd1);
      rst = 1'b0;

      run8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
      check("lat8", 128'(lat), 128'd5);
      check("w8_c0", {cout8, s8}, {1'b1, 8'h00});
      check("tag8", {127'd0, to8}, 128'd1);
      run8(8'hFF, 8'h01, 1'b1, 1'b0, lat);
      check("w8_c1", {cout8, s8}, {1'b1, 8'h01});
`ifdef KSA_SUB_EN
      run8(8'h80, 8'h01, 1'b0, 1'b1, lat);
      check("sub_ovf", {ovf8, s8}, {1'b1, 8'h7F});
      run8(8'h05, 8'h05, 1'b0, 1'b1, lat);
      check("sub_zero", {ovf8, cout8, s8}, {1'b0, 1'b1, 8'h00});
`endif

      run13(13'h1FFF, 13'h0000, 1'b1, lat);
      check("lat13", 128'(lat), 128'd6);
      check("w13_chain", {to13, cout13, s13}, {1'b1, 1'b1, 13'h0000});
      for (int i = 0; i < 4; i++) begin
         a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
         e = ref_add(13, {19'd0, a13}, {19'd0, b13}, cin13, 1'b0);
         run13(a13, b13, cin13, lat);
         check("w13_rand", {cout13, s13}, {e[32], e[12:0]});
`ifdef KSA_SUB_EN
         check("w13_ovf", {127'd0, ovf13}, {127'd0, e[33]});
`endif
      end

      misses = 0;
      for (int i = 0; i < 60; i++) begin
         step32(1'b1, 1'b1);
         if (i >= 7 && !ov32) misses++;
      end
      check("throughput", 128'(misses), 128'd0);

      step32(1'b0, 1'b1);
      snap = {to32, cout32, s32};
      check("hold_valid", {127'd0, ov32}, 128'd1);
      for (int i = 0; i < 10; i++) begin
         step32(1'b0, 1'b1);
         check("hold_ready", {127'd0, ir32}, 128'd0);
         check("hold_out", {to32, cout32, s32}, snap);
      end

      for (int i = 0; i < 200; i++)
         step32($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      for (int i = 0; i < 20; i++) step32(1'b1, 1'b0);
      check("drain", 128'(q.size()), 128'd0);

      repeat (3) step32(1'b1, 1'b1);
      @(negedge clk);
      iv32 = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_mid", {ov32, to32, cout32, s32}, 128'd0);
      @(posedge clk);
      #1;
      check("rst_edge", {127'd0, ov32}, 128'd0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;

      @(negedge clk);
      a32 = $urandom; b32 = $urandom; cin32 = 1'b1; sub32 = 1'b0;
      ti32 = 8'h5A; iv32 = 1'b1; or32 = 1'b1;
      e = ref_add(32, a32, b32, cin32, sub32);
      x.s = e[31:0]; x.c = e[32]; x.t = ti32;
      @(posedge clk);
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         iv32 = 1'b0;
         if (ov32) begin lat = n; break; end
      end
      check("lat32", 128'(lat), 128'd7);
      check("post_rst", {to32, cout32, s32}, {x.t, x.c, x.s});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
